// File: rtl/imem_pkg.sv
// Purpose: shared definitions for the instruction-memory loader and the memory it fills.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_pkg;

  // Width of the frame length header and of the payload byte counter
  localparam int LEN_W = 16;

  // Capacity of the instruction array in bytes; also the largest legal payload
  localparam int MEM_BYTES_DEF = 1025;

  typedef enum logic [2:0] {
    st_idle,
    st_len_lo,
    st_len_hi,
    st_data,
    st_chk,
    st_done,
    st_err
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// Purpose: receive a framed byte stream (len16 LSB-first, payload, checksum) and write it into imem.
// Latency: a payload byte accepted in cycle N is written (mem_we/mem_addr/mem_wdata) in cycle N+1.
// Backpressure: in_ready is state-decoded; in_valid gaps simply stall the frame without losing bytes.
module imem_loader
  import imem_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              MEM_BYTES = MEM_BYTES_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] cap = 32'(MEM_BYTES);

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [7:0]       sum;
  logic             xfer;
  logic [LEN_W-1:0] len_full;
  logic             too_big;
  logic             last;
  logic             can_start;

  assign xfer      = in_valid & in_ready;
  // Complete length as it will be once the high byte currently on the bus is taken
  assign len_full  = {in_data, len[7:0]};
  assign too_big   = {16'd0, len_full} > cap;
  assign last      = (cnt == len - 16'd1);
  assign can_start = (state == st_idle) || (state == st_done) || (state == st_err);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= st_idle;
    else        state <= state_nx;
  end

  // Next-state decode: header, payload, checksum, then a resting state until the next start
  always_comb begin
    state_nx = state;
    case (state)
      st_idle, st_done, st_err: if (start) state_nx = st_len_lo;
      st_len_lo: if (xfer) state_nx = st_len_hi;
      st_len_hi: begin
        if (xfer) begin
          if (too_big)              state_nx = st_err;
          else if (len_full == '0)  state_nx = st_chk;
          else                      state_nx = st_data;
        end
      end
      st_data: if (xfer && last) state_nx = st_chk;
      st_chk: begin
        if (xfer) state_nx = (in_data == sum) ? st_done : st_err;
      end
      default: state_nx = st_idle;
    endcase
  end

  // Datapath: length capture, payload counter, running checksum and the registered write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len       <= '0;
      cnt       <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        st_len_lo: if (xfer) len[7:0] <= in_data;
        st_len_hi: begin
          if (xfer) begin
            len[15:8] <= in_data;
            cnt       <= '0;
          end
        end
        st_data: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + ADDR_W'(cnt);
            mem_wdata <= in_data;
            sum       <= sum + in_data;
            cnt       <= cnt + 16'd1;
          end
        end
        default: if (can_start && start) sum <= '0;
      endcase
    end
  end

  // Status outputs are pure state decodes; done/err stay up until the next start leaves DONE/ERR
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      st_len_lo, st_len_hi, st_data, st_chk: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      st_done: done = 1'b1;
      st_err:  err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W   (32),
    .MEM_BYTES(1025),
    .BASE_ADDR(32'd0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [39:0] sb[$];
  logic [7:0]  bmem[0:2047];
  logic [7:0]  pay[0:1099];
  int          exp_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      bmem[mem_addr[10:0]] = mem_wdata;
      if (sb.size() == 0) begin
        chk("spurious_write", {31'd0, mem_we}, 32'd0);
      end else begin
        logic [39:0] e;
        e = sb.pop_front();
        chk("wr_addr", mem_addr, e[39:8]);
        chk("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit payload);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("hs_timeout", {31'd0, got}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (payload) begin
      sb.push_back({exp_addr[31:0], b});
      exp_addr++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (payload) begin
      chk("we_latency", {31'd0, mem_we}, 32'd1);
      chk("addr_latency", mem_addr, exp_addr - 1);
    end
  endtask

  task automatic send_frame(input logic [15:0] len, input logic [7:0] ck,
                            input bit gaps, input bit midstart);
    exp_addr = 0;
    send_byte(len[7:0], 1'b0);
    send_byte(len[15:8], 1'b0);
    for (int i = 0; i < int'(len); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      if (midstart && i == 10) begin
        pulse_start();
        chk("midstart_busy", {31'd0, busy}, 32'd1);
      end
      send_byte(pay[i], 1'b1);
    end
    send_byte(ck, 1'b0);
  endtask

  function automatic logic [7:0] psum(input int n);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < n; i++) s = s + pay[i];
    return s;
  endfunction

  task automatic chk_status(input string tag, input logic d, input logic e);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic chk_drained(input string tag);
    repeat (3) begin @(posedge clk); #1; end
    chk(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 2048; i++) bmem[i] = 8'h00;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Add instruction, good checksum
    pay[0] = 8'h33; pay[1] = 8'h89; pay[2] = 8'hA9; pay[3] = 8'h00;
    pulse_start();
    chk("lenlo_busy", {31'd0, busy}, 32'd1);
    chk("lenlo_rdy", {31'd0, in_ready}, 32'd1);
    send_frame(16'd4, 8'h65, 1'b0, 1'b0);
    chk_status("add_ok", 1'b1, 1'b0);
    chk("fetch0", {bmem[3], bmem[2], bmem[1], bmem[0]}, 32'h00A98933);
    chk_drained("add_ok_drained");

    // Same frame, bad checksum
    pulse_start();
    chk("restart_done_clr", {31'd0, done}, 32'd0);
    send_frame(16'd4, 8'h66, 1'b0, 1'b0);
    chk_status("add_bad", 1'b0, 1'b1);
    chk_drained("add_bad_drained");

    // Zero length
    pulse_start();
    chk("restart_err_clr", {31'd0, err}, 32'd0);
    send_frame(16'd0, 8'h00, 1'b0, 1'b0);
    chk_status("zero_ok", 1'b1, 1'b0);
    pulse_start();
    send_frame(16'd0, 8'h01, 1'b0, 1'b0);
    chk_status("zero_bad", 1'b0, 1'b1);
    chk_drained("zero_drained");

    // Oversize length 1026: error right after the header, no writes
    pulse_start();
    exp_addr = 0;
    send_byte(8'h02, 1'b0);
    send_byte(8'h04, 1'b0);
    chk_status("oversize", 1'b0, 1'b1);
    chk_drained("oversize_drained");

    // Maximum length 1025
    for (int i = 0; i < 1025; i++) pay[i] = 8'($urandom);
    pulse_start();
    send_frame(16'd1025, psum(1025), 1'b0, 1'b0);
    chk_status("max_len", 1'b1, 1'b0);
    chk("max_last_addr", mem_addr, 32'd1024);
    chk_drained("max_drained");
    chk("max_last_byte", {24'd0, bmem[1024]}, {24'd0, pay[1024]});

    // Backpressure with random gaps and an ignored mid-frame start
    for (int i = 0; i < 20; i++) pay[i] = 8'($urandom);
    pulse_start();
    send_frame(16'd20, psum(20), 1'b1, 1'b1);
    chk_status("bp", 1'b1, 1'b0);
    chk("bp_last_addr", mem_addr, 32'd19);
    chk_drained("bp_drained");

    // Reset after the third payload byte
    pulse_start();
    exp_addr = 0;
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(pay[i], 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_rdy", {31'd0, in_ready}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_drained("midrst_drained");

    pay[0] = 8'h13; pay[1] = 8'h05; pay[2] = 8'h10; pay[3] = 8'h00;
    pulse_start();
    send_frame(16'd4, psum(4), 1'b0, 1'b0);
    chk_status("post_rst", 1'b1, 1'b0);
    chk_drained("post_rst_drained");
    chk("post_rst_fetch", {bmem[3], bmem[2], bmem[1], bmem[0]}, 32'h00100513);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
